dsram_req_master: RTL and testbench

Data-side request master between the EX stage and the SRAM-like data bus: accepts one load/store per handshake, aligns store data, generates byte strobes, and runs the req/addr_ok/data_ok transaction to completion. It is the write/issue end of the data-memory path. The MEM stage consumes `resp_valid`/`resp_rdata` and performs its own byte/half extraction and sign extension. At most one transaction is outstanding.

---
 rtl/dsram_pkg.sv | 21 ++
 rtl/store_align.sv | 41 ++++
 rtl/dsram_req_master.sv | 151 +++++++++++++++
 tb/tb_dsram_req_master.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsram_pkg.sv
// Shared types for the data-side SRAM request master: bus size codes and FSM states.
// No logic; constants and one helper only.
// Imported by dsram_req_master and store_align.
package dsram_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    // Size code 11 is treated as a word on the bus.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SIZE_W : size;
    endfunction

endpackage

// File: rtl/store_align.sv
// Store alignment: byte strobes, replicated store data and misalignment flag.
// Latency: purely combinational.
// Backpressure: none; evaluated whenever inputs change.
module store_align
    import dsram_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        wr_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o
);

    // Strobe/data replication by size; loads never drive strobes.
    always_comb begin
        wstrb_o      = 4'b1111;
        wdata_o      = wdata_i;
        misaligned_o = 1'b0;
        case (size_i)
            SIZE_B: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SIZE_H: begin
                wstrb_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            default: begin
                wstrb_o      = 4'b1111;
                misaligned_o = (addr_lo_i != 2'b00);
            end
        endcase
        if (!wr_i) begin
            wstrb_o = 4'b0000;
        end
    end

endmodule

// File: rtl/dsram_req_master.sv
// Data-side request master: one load/store per handshake onto the req/addr_ok/data_ok SRAM bus.
// Latency: accept in N, data_sram_req in N+1, resp_valid combinational on data_ok in WAIT.
// Backpressure: req_ready only in IDLE or on the WAIT data_ok cycle; flush cancels. Option: DSRAM_ALIGN_CHECK_EN.
module dsram_req_master
    import dsram_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        ale,
    output logic        busy
);

    state_e      state_q, state_d;
    logic        cancel_q, cancel_d;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic        al_misaligned;
    logic        accept;
    logic        issue;

    store_align u_align (
        .size_i       (req_size),
        .addr_lo_i    (req_addr[1:0]),
        .wr_i         (req_wr),
        .wdata_i      (req_wdata),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata),
        .misaligned_o (al_misaligned)
    );

    assign req_ready = (state_q == IDLE) || ((state_q == WAIT) && data_sram_data_ok);
    assign accept    = req_valid && req_ready && !flush;

`ifdef DSRAM_ALIGN_CHECK_EN
    logic ale_q;

    // A misaligned op is swallowed at accept; only the alignment exception is raised.
    assign issue = accept && !al_misaligned;
    assign ale   = ale_q;

    // One-cycle alignment exception pulse following the accept.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ale_q <= 1'b0;
        end else begin
            ale_q <= accept && al_misaligned;
        end
    end
`else
    logic unused_misaligned;

    assign unused_misaligned = al_misaligned;
    assign issue             = accept;
    assign ale               = 1'b0;
`endif

    // Next-state and cancel tracking for the single outstanding transaction.
    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d  = REQ;
                    cancel_d = 1'b0;
                end
            end
            REQ: begin
                if (data_sram_addr_ok) begin
                    // Address already taken: the data phase must still be drained.
                    state_d  = WAIT;
                    cancel_d = cancel_q || flush;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (flush) begin
                    cancel_d = 1'b1;
                end
                if (data_sram_data_ok) begin
                    state_d  = issue ? REQ : IDLE;
                    cancel_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                cancel_d = 1'b0;
            end
        endcase
    end

    // State register plus bus fields latched on issue and held until the next issue.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cancel_q <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            wstrb_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            if (issue) begin
                wr_q    <= req_wr;
                size_q  <= norm_size(req_size);
                addr_q  <= req_addr;
                wdata_q <= al_wdata;
                wstrb_q <= al_wstrb;
            end
        end
    end

    assign data_sram_req   = (state_q == REQ);
    assign data_sram_wr    = wr_q;
    assign data_sram_size  = size_q;
    assign data_sram_addr  = addr_q;
    assign data_sram_wstrb = wstrb_q;
    assign data_sram_wdata = wdata_q;

    assign resp_valid = (state_q == WAIT) && data_sram_data_ok && !cancel_q;
    assign resp_rdata = data_sram_rdata;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dsram_req_master.sv
// Directed bench for dsram_req_master: stimulus pushes expected bus requests and responses
// into queues, a negedge monitor pops and compares them on every address handshake and
// resp_valid; cycle-exact checks cover latency, stability, flush, reset and alignment.
module tb_dsram_req_master;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        flush;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        ale;
    logic        busy;

    int nvec  = 0;
    int nfail = 0;

    bus_t        exp_bus[$];
    logic [31:0] exp_rd[$];

    dsram_req_master dut (
        .clk               (clk),
        .resetn            (resetn),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_wr            (req_wr),
        .req_size          (req_size),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .flush             (flush),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .resp_valid        (resp_valid),
        .resp_rdata        (resp_rdata),
        .ale               (ale),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic cyc();
        @(posedge clk);
        #1;
        req_valid         = 1'b0;
        flush             = 1'b0;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic offer(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid = 1'b1;
        req_wr    = wr;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic push_bus(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [3:0] wstrb, input logic [31:0] wdata);
        bus_t b;
        b.wr = wr; b.size = size; b.addr = addr; b.wstrb = wstrb; b.wdata = wdata;
        exp_bus.push_back(b);
    endtask

    // Scoreboard monitor: compares every address handshake and every response.
    always @(negedge clk) begin
        if (data_sram_req && data_sram_addr_ok) begin
            if (exp_bus.size() == 0) begin
                chk("unexpected_bus_req", data_sram_addr, 32'hFFFF_FFFF);
            end else begin
                bus_t e;
                e = exp_bus.pop_front();
                chk("bus_wr", {31'h0, data_sram_wr}, {31'h0, e.wr});
                chk("bus_size", {30'h0, data_sram_size}, {30'h0, e.size});
                chk("bus_addr", data_sram_addr, e.addr);
                chk("bus_wstrb", {28'h0, data_sram_wstrb}, {28'h0, e.wstrb});
                chk("bus_wdata", data_sram_wdata, e.wdata);
            end
        end
        if (resp_valid) begin
            if (exp_rd.size() == 0) begin
                chk("unexpected_resp", resp_rdata, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] r;
                r = exp_rd.pop_front();
                chk("resp_rdata", resp_rdata, r);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_addr = 32'h0; req_wdata = 32'h0;
        flush = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;

        // ---- reset state
        repeat (3) cyc();
        samp();
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_req", {31'h0, data_sram_req}, 32'h0);
        chk("rst_wr", {31'h0, data_sram_wr}, 32'h0);
        chk("rst_addr", data_sram_addr, 32'h0);
        chk("rst_wstrb", {28'h0, data_sram_wstrb}, 32'h0);
        chk("rst_wdata", data_sram_wdata, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_ale", {31'h0, ale}, 32'h0);
        cyc(); resetn = 1'b1;
        samp();
        chk("idle_ready", {31'h0, req_ready}, 32'h1);

        // ---- st.b 0x1003: addr_ok N+1, data_ok N+3
        cyc(); offer(1'b1, 2'b00, 32'h0000_1003, 32'h0000_00A5);
        push_bus(1'b1, 2'b00, 32'h0000_1003, 4'b1000, 32'hA5A5_A5A5);
        samp(); chk("stb_N_req", {31'h0, data_sram_req}, 32'h0);
        cyc(); data_sram_addr_ok = 1'b1;
        samp(); chk("stb_N1_req", {31'h0, data_sram_req}, 32'h1);
        chk("stb_N1_resp", {31'h0, resp_valid}, 32'h0);
        cyc();
        samp(); chk("stb_N2_req", {31'h0, data_sram_req}, 32'h0);
        chk("stb_N2_resp", {31'h0, resp_valid}, 32'h0);
        chk("stb_N2_busy", {31'h0, busy}, 32'h1);
        cyc(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
        exp_rd.push_back(32'h1111_1111);
        samp(); chk("stb_N3_resp", {31'h0, resp_valid}, 32'h1);
        cyc();
        samp(); chk("stb_N4_resp", {31'h0, resp_valid}, 32'h0);
        chk("stb_N4_busy", {31'h0, busy}, 32'h0);

        // ---- st.h 0x2002: addr_ok delayed 3 cycles, fields stable
        cyc(); offer(1'b1, 2'b01, 32'h0000_2002, 32'h1234_BEEF);
        push_bus(1'b1, 2'b01, 32'h0000_2002, 4'b1100, 32'hBEEF_BEEF);
        for (int i = 0; i < 3; i++) begin
            cyc();
            req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; // changing inputs must not disturb the bus
            samp();
            chk("sth_hold_req", {31'h0, data_sram_req}, 32'h1);
            chk("sth_hold_addr", data_sram_addr, 32'h0000_2002);
            chk("sth_hold_wstrb", {28'h0, data_sram_wstrb}, 32'h0000_000C);
            chk("sth_hold_wdata", data_sram_wdata, 32'hBEEF_BEEF);
        end
        cyc(); data_sram_addr_ok = 1'b1;
        samp();
        cyc(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h2222_2222;
        exp_rd.push_back(32'h2222_2222);
        samp(); chk("sth_resp", {31'h0, resp_valid}, 32'h1);
        cyc();
        samp();

        // ---- ld.w 0x3000 then back-to-back st.w 0x3004 accepted on data_ok
        cyc(); offer(1'b0, 2'b10, 32'h0000_3000, 32'h0);
        push_bus(1'b0, 2'b10, 32'h0000_3000, 4'b0000, 32'h0);
        samp();
        cyc(); data_sram_addr_ok = 1'b1;
        samp();
        cyc(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
        offer(1'b1, 2'b10, 32'h0000_3004, 32'hCAFE_F00D);
        exp_rd.push_back(32'hDEAD_BEEF);
        push_bus(1'b1, 2'b10, 32'h0000_3004, 4'b1111, 32'hCAFE_F00D);
        samp(); chk("ldw_resp", {31'h0, resp_valid}, 32'h1);
        chk("b2b_ready", {31'h0, req_ready}, 32'h1);
        cyc(); data_sram_addr_ok = 1'b1;
        samp(); chk("b2b_next_req", {31'h0, data_sram_req}, 32'h1);
        cyc(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h3333_3333;
        exp_rd.push_back(32'h3333_3333);
        samp(); chk("b2b_resp", {31'h0, resp_valid}, 32'h1);
        cyc();
        samp(); chk("b2b_idle", {31'h0, busy}, 32'h0);

        // ---- flush in REQ without addr_ok
        cyc(); offer(1'b1, 2'b10, 32'h0000_5000, 32'h5555_5555);
        samp();
        cyc(); flush = 1'b1;
        samp(); chk("flreq_req_still", {31'h0, data_sram_req}, 32'h1);
        cyc();
        samp(); chk("flreq_req_drop", {31'h0, data_sram_req}, 32'h0);
        chk("flreq_busy", {31'h0, busy}, 32'h0);
        cyc(); data_sram_data_ok = 1'b1;
        samp(); chk("flreq_stray_dok", {31'h0, resp_valid}, 32'h0);

        // ---- flush in WAIT: later data_ok suppressed
        cyc(); offer(1'b0, 2'b10, 32'h0000_6000, 32'h0);
        push_bus(1'b0, 2'b10, 32'h0000_6000, 4'b0000, 32'h0);
        samp();
        cyc(); data_sram_addr_ok = 1'b1;
        samp();
        cyc(); flush = 1'b1;
        samp();
        cyc();
        samp(); chk("flwait_busy", {31'h0, busy}, 32'h1);
        cyc(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h6666_6666;
        samp(); chk("flwait_resp", {31'h0, resp_valid}, 32'h0);
        cyc();
        samp(); chk("flwait_idle", {31'h0, busy}, 32'h0);

        // ---- flush on the data_ok cycle blocks the new accept
        cyc(); offer(1'b0, 2'b10, 32'h0000_7000, 32'h0);
        push_bus(1'b0, 2'b10, 32'h0000_7000, 4'b0000, 32'h0);
        samp();
        cyc(); data_sram_addr_ok = 1'b1;
        samp();
        cyc(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h7777_7777; flush = 1'b1;
        offer(1'b1, 2'b10, 32'h0000_7004, 32'h1);
        exp_rd.push_back(32'h7777_7777);
        samp(); chk("fldok_resp", {31'h0, resp_valid}, 32'h1);
        cyc();
        samp(); chk("fldok_no_req", {31'h0, data_sram_req}, 32'h0);
        chk("fldok_idle", {31'h0, busy}, 32'h0);

        // ---- misaligned ld.w 0x4002
        cyc(); offer(1'b0, 2'b10, 32'h0000_4002, 32'h0);
`ifdef DSRAM_ALIGN_CHECK_EN
        samp();
        cyc();
        samp(); chk("ale_pulse", {31'h0, ale}, 32'h1);
        chk("ale_no_req", {31'h0, data_sram_req}, 32'h0);
        chk("ale_idle", {31'h0, busy}, 32'h0);
        cyc();
        samp(); chk("ale_one_cycle", {31'h0, ale}, 32'h0);
        chk("ale_no_req2", {31'h0, data_sram_req}, 32'h0);
`else
        push_bus(1'b0, 2'b10, 32'h0000_4002, 4'b0000, 32'h0);
        samp();
        cyc(); data_sram_addr_ok = 1'b1;
        samp(); chk("mis_req", {31'h0, data_sram_req}, 32'h1);
        chk("mis_ale", {31'h0, ale}, 32'h0);
        cyc(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h4444_4444;
        exp_rd.push_back(32'h4444_4444);
        samp(); chk("mis_resp", {31'h0, resp_valid}, 32'h1);
        cyc();
        samp();
`endif

        // ---- reset during WAIT
        cyc(); offer(1'b1, 2'b00, 32'h0000_8001, 32'h0000_0099);
        push_bus(1'b1, 2'b00, 32'h0000_8001, 4'b0010, 32'h9999_9999);
        samp();
        cyc(); data_sram_addr_ok = 1'b1;
        samp();
        cyc(); resetn = 1'b0;
        samp(); chk("rstw_busy_before", {31'h0, busy}, 32'h1);
        cyc(); resetn = 1'b1;
        samp(); chk("rstw_busy", {31'h0, busy}, 32'h0);
        chk("rstw_req", {31'h0, data_sram_req}, 32'h0);
        chk("rstw_wstrb", {28'h0, data_sram_wstrb}, 32'h0);
        chk("rstw_addr", data_sram_addr, 32'h0);
        cyc(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8888_8888;
        samp(); chk("rstw_dok_ignored", {31'h0, resp_valid}, 32'h0);
        chk("rstw_ready", {31'h0, req_ready}, 32'h1);
        cyc();
        samp();

        chk("bus_queue_drained", exp_bus.size(), 32'h0);
        chk("resp_queue_drained", exp_rd.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
